spi_slave_gen: RTL
==================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 Parameter DATA_W, default 8, is the payload width in bits for both address and data frames.
REQ-002 Parameter TX_TIMEOUT, default 16, is the maximum number of clk cycles to wait for tx_valid in a read-data frame.
REQ-003 Derived localparam RX_W = DATA_W + 2 is the received frame width: 2 command bits followed by DATA_W payload bits.
REQ-004 clk  input  1  system clock; MOSI is sampled and MISO is driven on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 SS_n  input  1  slave select, active-low; high delimits frames.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 rx_data  output  RX_W  last complete received frame: {cmd[1:0], payload}.
REQ-010 rx_valid  output  1  one-cycle pulse qualifying rx_data.
REQ-011 tx_data  input  DATA_W  read data from the memory side.
REQ-012 tx_valid  input  1  tx_data valid; sampled only in WAIT_TX.
REQ-013 frame_err  output  1  one-cycle pulse on an aborted or illegal frame.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, RECV, WAIT_TX, SEND and DONE.
REQ-016 IDLE: on a rising edge with SS_n=0 -> RECV; the bit counter loads RX_W and the bit on MOSI at that edge is NOT sampled.
REQ-017 RECV: each edge with SS_n=0 shifts MOSI into the receive shift register and decrements the counter.
REQ-018 Frame completion: after the RX_W-th sampled bit, rx_data takes the shift register and rx_valid is high for exactly the next cycle, i.e. rx_valid is registered one cycle after the last sample edge.
REQ-019 Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-020 A completed 10 frame sets the internal addr_rcvd flag; 00, 01 and 10 frames -> DONE.
REQ-021 A completed 11 frame with addr_rcvd=1 -> WAIT_TX; with addr_rcvd=0 it still pulses rx_valid but also pulses frame_err, then -> DONE.
REQ-022 WAIT_TX: tx_valid=1 loads tx_data into the transmit shift register -> SEND.
REQ-023 WAIT_TX timeout: after TX_TIMEOUT cycles without tx_valid, pulse frame_err, clear addr_rcvd, -> DONE.
REQ-024 SEND: MISO presents tx_data[DATA_W-1] on the first SEND cycle, then one bit per cycle for DATA_W cycles in total.
REQ-025 After the last SEND bit, clear addr_rcvd -> DONE.
REQ-026 DONE: hold until SS_n=1; extra MOSI bits are ignored.
REQ-027 SS_n=1 in any non-IDLE state -> IDLE on the next edge, with priority over every other transition.
REQ-028 SS_n=1 in RECV before RX_W bits, or in SEND before DATA_W bits, pulses frame_err, suppresses rx_valid and leaves rx_data unchanged.
REQ-029 SS_n=1 in WAIT_TX pulses frame_err and keeps addr_rcvd.
REQ-030 MISO SHALL be 0 in every state except SEND.
REQ-031 rx_valid and frame_err never assert in the same cycle, except in the REQ-021 case.

Reset
REQ-032 rst_n=0 at an edge forces state=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, addr_rcvd=0 and clears the counters, overriding any frame in progress.
REQ-033 The first edge after rst_n returns high is treated as IDLE, so a frame needs a fresh SS_n low sample.

Structure
REQ-034 Package spi_gen_pkg SHALL hold the state enum, the 2-bit command enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the command width constant 2.
REQ-035 One sub-module, spi_shift_reg (parametrised width, load, shift-in, shift-out MSB), SHALL be instantiated twice: once for receive and once for transmit.

Verification
REQ-036 DATA_W=8, SS_n low, 10 bits 00_10100101, SS_n high -> rx_data=10'h0A5 with a single rx_valid pulse on the cycle after the 10th sample; MISO stays 0.
REQ-037 A 10_00001111 frame, then a new frame 11_xxxxxxxx, tx_valid=1 with tx_data=8'hC3 three cycles later -> MISO serialises 1,1,0,0,0,0,1,1 on consecutive cycles, then addr_rcvd=0.
REQ-038 A read-data frame with no prior read-address frame -> rx_valid and frame_err together, then no MISO activity.
REQ-039 tx_valid held low for 16 cycles in WAIT_TX -> frame_err on the 17th cycle, DONE reached, and a following read-data frame raises frame_err (addr_rcvd cleared).
REQ-040 SS_n raised after 5 bits of a write frame -> frame_err pulse, no rx_valid, rx_data unchanged, IDLE next cycle.
REQ-041 rst_n low mid-SEND -> MISO=0 and all outputs at reset values on the next cycle; DATA_W=16 rerun of REQ-036 with RX_W=18 passes.

Source files
------------

// File: rtl/spi_gen_pkg.sv
// Shared types for the SPI slave: FSM state encoding and the 2-bit frame command codes.
package spi_gen_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WAIT_TX,
    SEND,
    DONE
  } state_t;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with parallel load; load takes priority over shift.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q,
  output logic         sout
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)        r_q <= '0;
    else if (load)     r_q <= load_val;
    else if (shift_en) r_q <= {r_q[W-2:0], shift_in};
  end

  assign q    = r_q;
  assign sout = r_q[W-1];

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave with a 2-bit command prefix per frame; read-data frames serialise tx_data on MISO
// once a read-address frame has been seen and the memory side answers within TX_TIMEOUT cycles.
module spi_slave_gen
  import spi_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    MOSI,
  output logic                    MISO,
  output logic [DATA_W+CMD_W-1:0] rx_data,
  output logic                    rx_valid,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int RX_W  = DATA_W + CMD_W;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int TMO_W = $clog2(TX_TIMEOUT + 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_next;
  logic               r_addr_rcvd, w_addr_rcvd_next;
  logic [RX_W-1:0]    r_rx_data, w_rx_data_next;
  logic               r_rx_valid, w_rx_valid_next;
  logic               r_frame_err, w_frame_err_next;

  logic               w_rx_load, w_rx_shift_en, w_rx_sout;
  logic               w_tx_load, w_tx_shift_en, w_tx_sout;
  logic [RX_W-1:0]    w_rx_q, w_rx_frame;
  logic [DATA_W-1:0]  w_tx_q;
  cmd_t               w_cmd;
  logic               w_unused;

  spi_shift_reg #(.W(RX_W)) u_rx_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_rx_load),
    .load_val ('0),
    .shift_en (w_rx_shift_en),
    .shift_in (MOSI),
    .q        (w_rx_q),
    .sout     (w_rx_sout)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tx_load),
    .load_val (tx_data),
    .shift_en (w_tx_shift_en),
    .shift_in (1'b0),
    .q        (w_tx_q),
    .sout     (w_tx_sout)
  );

  // The frame is complete on the edge that samples its last bit, so decode the shifted-in view.
  assign w_rx_frame = {w_rx_q[RX_W-2:0], MOSI};
  assign w_cmd      = cmd_t'(w_rx_frame[RX_W-1 -: CMD_W]);
  assign w_unused   = ^{w_rx_q[RX_W-1], w_rx_sout, w_tx_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_addr_rcvd <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_addr_rcvd <= w_addr_rcvd_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_tmo_cnt_next   = r_tmo_cnt;
    w_addr_rcvd_next = r_addr_rcvd;
    w_rx_data_next   = r_rx_data;
    w_rx_valid_next  = 1'b0;
    w_frame_err_next = 1'b0;
    w_rx_load        = 1'b0;
    w_rx_shift_en    = 1'b0;
    w_tx_load        = 1'b0;
    w_tx_shift_en    = 1'b0;
    if (SS_n) begin
      // Deselect always wins; it is only an error while bits are still owed in either direction.
      w_state_next = IDLE;
      if (r_state == RECV || r_state == WAIT_TX || r_state == SEND) w_frame_err_next = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next   = RECV;
          w_bit_cnt_next = CNT_W'(RX_W);
          w_rx_load      = 1'b1;
        end
        RECV: begin
          w_rx_shift_en  = 1'b1;
          w_bit_cnt_next = r_bit_cnt - 1'b1;
          if (r_bit_cnt == CNT_W'(1)) begin
            w_rx_data_next  = w_rx_frame;
            w_rx_valid_next = 1'b1;
            w_state_next    = DONE;
            case (w_cmd)
              CMD_RD_ADDR: w_addr_rcvd_next = 1'b1;
              CMD_RD_DATA: begin
                if (r_addr_rcvd) begin
                  w_state_next   = WAIT_TX;
                  w_tmo_cnt_next = '0;
                end else begin
                  w_frame_err_next = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            w_tx_load      = 1'b1;
            w_bit_cnt_next = CNT_W'(DATA_W);
            w_state_next   = SEND;
          end else if (r_tmo_cnt == TMO_W'(TX_TIMEOUT - 1)) begin
            w_frame_err_next = 1'b1;
            w_addr_rcvd_next = 1'b0;
            w_state_next     = DONE;
          end else begin
            w_tmo_cnt_next = r_tmo_cnt + 1'b1;
          end
        end
        SEND: begin
          w_tx_shift_en  = 1'b1;
          w_bit_cnt_next = r_bit_cnt - 1'b1;
          if (r_bit_cnt == CNT_W'(1)) begin
            w_addr_rcvd_next = 1'b0;
            w_state_next     = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign MISO      = (r_state == SEND) && w_tx_sout;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
